uart_rx: RTL and testbench

Asynchronous serial receiver, 8N1 format, LSB first; the receiving end of the link driven by uart_tx.
- Synchronises the rx pin into clk, detects and validates the start bit, samples each bit at mid-bit, checks the stop bit.
- Presents the received byte with a one-cycle strobe.
- Sits between the board RX pin and the user logic, e.g. loopback or a command parser.

---
 rtl/uart_rx_pkg.sv | 37 +++
 rtl/uart_rx_if.sv | 35 +++
 rtl/rx_baud_sampler.sv | 53 +++++
 rtl/uart_rx.sv | 124 ++++++++++++
 tb/tb_uart_rx.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// +----------------------------------------------------------------------------+
// | uart_rx_pkg : shared baud divisors, byte/counter types and helpers for     |
// |               the 8N1 receiver.                                            |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

// Divisors in clk cycles per bit at 12 MHz, shared with the transmitter.
`ifndef UART_BAUD_DEFS
`define UART_BAUD_DEFS
`define B115200 104
`define B57600  208
`define B38400  313
`define B19200  625
`define B9600   1250
`define B4800   2500
`define B2400   5000
`define B1200   10000
`define B600    20000
`define B300    40000
`endif

package uart_rx_pkg;

  localparam int DATA_BITS = 8;

  typedef logic [DATA_BITS-1:0] byte_t;
  typedef logic [3:0]           bitcnt_t;

  function automatic int half_period(input int baud);
    return baud / 2;
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// +----------------------------------------------------------------------------+
// | uart_rx_if : serial pin plus received-byte side of the UART receiver.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

interface uart_rx_if;
  import uart_rx_pkg::*;

  logic  rx;
  byte_t data;
  logic  rcv;
  logic  ferr;
  logic  busy;

  modport master (
    output rx,
    input  data,
    input  rcv,
    input  ferr,
    input  busy
  );

  modport slave (
    input  rx,
    output data,
    output rcv,
    output ferr,
    output busy
  );

endinterface

`default_nettype wire

// File: rtl/rx_baud_sampler.sv
// +----------------------------------------------------------------------------+
// | rx_baud_sampler : mid-bit tick generator, first tick half a bit after      |
// |                   enable, then one tick per bit period.                    |
// | Revision        : 1.0                                                      |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module rx_baud_sampler
  import uart_rx_pkg::*;
#(
  parameter int BAUDRATE = `B9600
) (
  input  wire logic clk,
  input  wire logic rstn,
  input  wire logic clk_ena,
  output logic      tick
);

  localparam int            CW        = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_period(BAUDRATE) - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BAUDRATE - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          first_q, first_d;

  // first_q selects the half-period target for the very first tick.
  always_comb begin
    tick    = clk_ena && (cnt_q == (first_q ? HALF_LAST : FULL_LAST));
    cnt_d   = cnt_q + 1'b1;
    first_d = first_q;
    if (!clk_ena) begin
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (tick) begin
      cnt_d   = '0;
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      first_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// +----------------------------------------------------------------------------+
// | uart_rx : 8N1 LSB-first asynchronous receiver with framing-error and       |
// |           line-break handling.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int BAUDRATE = `B9600
) (
  input  wire logic  clk,
  input  wire logic  rstn,
  uart_rx_if.slave   bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic [1:0] sync_q;
  logic       rx_s;
  logic [2:0] state_q, state_d;
  bitcnt_t    bitcnt_q, bitcnt_d;
  byte_t      shift_q, shift_d;
  byte_t      data_q, data_d;
  logic       rcv_q, rcv_d;
  logic       ferr_q, ferr_d;
  logic       sampler_ena;
  logic       tick;

  assign rx_s = sync_q[1];

  // Sampler runs only while a frame is being timed; BREAK just watches the line.
  assign sampler_ena = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);

  rx_baud_sampler #(
    .BAUDRATE (BAUDRATE)
  ) u_sampler (
    .clk     (clk),
    .rstn    (rstn),
    .clk_ena (sampler_ena),
    .tick    (tick)
  );

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    data_d   = data_q;
    rcv_d    = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d  = {rx_s, shift_q[DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == bitcnt_t'(DATA_BITS - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (rx_s) begin
            data_d  = shift_q;
            rcv_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q   <= 2'b11;
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      shift_q  <= '1;
      data_q   <= '0;
      rcv_q    <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], bus.rx};
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
      rcv_q    <= rcv_d;
      ferr_q   <= ferr_d;
    end
  end

  assign bus.data = data_q;
  assign bus.rcv  = rcv_q;
  assign bus.ferr = ferr_q;
  assign bus.busy = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// +----------------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx at BAUDRATE 16 and 1250.      |
// | Revision   : 1.0                                                           |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_uart_rx;

  localparam int B = 16;
  localparam int BT = 1250;

  typedef struct {
    logic [7:0] tx;
    logic       stop;
    int         gap;
    int         exp_rcv;
    int         exp_ferr;
    logic [7:0] exp_data;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic rx16 = 1'b1;
  logic rxt = 1'b1;
  int   cyc = 0;
  int   nvec = 0;
  int   nfail = 0;

  logic [7:0] got16[$];
  int         gotcyc16[$];
  int         ferr16 = 0;
  logic [7:0] gott[$];
  int         ferrt = 0;

  uart_rx_if bus16 ();
  uart_rx_if bust ();

  assign bus16.rx = rx16;
  assign bust.rx  = rxt;

  uart_rx #(.BAUDRATE(B))  dut16 (.clk(clk), .rstn(rstn), .bus(bus16));
  uart_rx #(.BAUDRATE(BT)) dutt  (.clk(clk), .rstn(rstn), .bus(bust));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus16.rcv === 1'b1) begin
      got16.push_back(bus16.data);
      gotcyc16.push_back(cyc);
    end
    if (bus16.ferr === 1'b1) ferr16 = ferr16 + 1;
    if (bust.rcv === 1'b1) gott.push_back(bust.data);
    if (bust.ferr === 1'b1) ferrt = ferrt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input int n);
    if (which == 0) rx16 = v; else rxt = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int which, input logic [7:0] b, input logic stop, input int p);
    drive(which, 1'b0, p);
    for (int i = 0; i < 8; i++) drive(which, b[i], p);
    drive(which, stop, p);
  endtask

  initial begin
    vec_t       tbl[6];
    int         br, bf, start, busy_cnt;
    logic [7:0] model_data, b;
    logic       stop;
    int         gap;

    tbl[0] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    tbl[1] = '{8'hFF, 1'b1, 0, 1, 0, 8'hFF};
    tbl[2] = '{8'h55, 1'b1, 0, 1, 0, 8'h55};
    tbl[3] = '{8'h3C, 1'b1, 1, 1, 0, 8'h3C};
    tbl[4] = '{8'h81, 1'b0, 2, 0, 1, 8'h3C};
    tbl[5] = '{8'hE7, 1'b1, 1, 1, 0, 8'hE7};

    // Reset values
    #2 rstn = 1'b0;
    #1;
    check("rst_data", bus16.data, 8'h00);
    check("rst_rcv",  bus16.rcv,  1'b0);
    check("rst_ferr", bus16.ferr, 1'b0);
    check("rst_busy", bus16.busy, 1'b0);
    repeat (4) @(posedge clk);
    #1 rstn = 1'b1;
    drive(0, 1'b1, 2 * B);

    // Single A5 with latency
    br = got16.size(); bf = ferr16; start = cyc;
    send_frame(0, 8'hA5, 1'b1, B);
    drive(0, 1'b1, B);
    check("a5_count", got16.size() - br, 1);
    if (got16.size() > br) begin
      check("a5_data", got16[br], 8'hA5);
      check("a5_latency_ok", ((gotcyc16[br] - start) >= 154 && (gotcyc16[br] - start) <= 156), 1'b1);
    end
    check("a5_ferr", ferr16 - bf, 0);

    // Table vectors incl. back-to-back stream and a bad stop bit
    for (int v = 0; v < 6; v++) begin
      br = got16.size(); bf = ferr16;
      send_frame(0, tbl[v].tx, tbl[v].stop, B);
      drive(0, 1'b1, tbl[v].gap * B);
      check($sformatf("tbl%0d_rcv", v), got16.size() - br, tbl[v].exp_rcv);
      check($sformatf("tbl%0d_ferr", v), ferr16 - bf, tbl[v].exp_ferr);
      check($sformatf("tbl%0d_data", v), bus16.data, tbl[v].exp_data);
    end

    // Line break: bad stop then 40 bit times low
    br = got16.size(); bf = ferr16;
    send_frame(0, 8'h81, 1'b0, B);
    drive(0, 1'b0, 40 * B);
    check("brk_busy_low_line", bus16.busy, 1'b1);
    drive(0, 1'b1, 2 * B);
    check("brk_ferr", ferr16 - bf, 1);
    check("brk_rcv", got16.size() - br, 0);
    check("brk_data", bus16.data, 8'hE7);
    check("brk_busy", bus16.busy, 1'b0);
    br = got16.size();
    send_frame(0, 8'h42, 1'b1, B);
    drive(0, 1'b1, B);
    check("brk_after_rcv", got16.size() - br, 1);
    check("brk_after_data", bus16.data, 8'h42);

    // Glitch on idle line
    br = got16.size(); bf = ferr16; busy_cnt = 0;
    fork
      begin
        drive(0, 1'b0, 4);
        drive(0, 1'b1, 1);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          @(negedge clk);
          if (bus16.busy === 1'b1) busy_cnt++;
        end
      end
    join
    drive(0, 1'b1, 2 * B);
    check("glitch_busy_cycles", busy_cnt, 8);
    check("glitch_rcv", got16.size() - br, 0);
    check("glitch_ferr", ferr16 - bf, 0);
    check("glitch_busy_end", bus16.busy, 1'b0);

    // Reset in the middle of bit 4 of C3
    br = got16.size(); bf = ferr16;
    drive(0, 1'b0, B);
    for (int i = 0; i < 4; i++) drive(0, tbl[0].tx[0] ^ (8'hC3 >> i) & 1'b1, B);
    drive(0, 1'b0, B / 2);
    rstn = 1'b0;
    #1;
    check("mid_rst_data", bus16.data, 8'h00);
    check("mid_rst_rcv",  bus16.rcv,  1'b0);
    check("mid_rst_ferr", bus16.ferr, 1'b0);
    check("mid_rst_busy", bus16.busy, 1'b0);
    rx16 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    drive(0, 1'b1, 2 * B);
    check("mid_rst_no_rcv", got16.size() - br, 0);
    check("mid_rst_no_ferr", ferr16 - bf, 0);
    br = got16.size();
    send_frame(0, 8'h5A, 1'b1, B);
    drive(0, 1'b1, B);
    check("after_rst_rcv", got16.size() - br, 1);
    check("after_rst_data", bus16.data, 8'h5A);

    // Randomized frames against a frame-level model
    model_data = 8'h5A;
    for (int n = 0; n < 25; n++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 9) != 0);
      gap  = $urandom_range(0, 2) + (stop ? 0 : 1);
      br = got16.size(); bf = ferr16;
      send_frame(0, b, stop, B);
      drive(0, 1'b1, gap * B);
      if (stop) model_data = b;
      check($sformatf("rnd%0d_rcv", n), got16.size() - br, stop ? 1 : 0);
      check($sformatf("rnd%0d_ferr", n), ferr16 - bf, stop ? 0 : 1);
      check($sformatf("rnd%0d_data", n), bus16.data, model_data);
    end

    // Baud tolerance at 1250 cycles/bit, sender -3% and +3%
    drive(1, 1'b1, BT);
    for (int k = 0; k < 2; k++) begin
      br = gott.size(); bf = ferrt;
      send_frame(1, 8'h96, 1'b1, (k == 0) ? 1212 : 1288);
      drive(1, 1'b1, BT);
      check($sformatf("tol%0d_rcv", k), gott.size() - br, 1);
      check($sformatf("tol%0d_ferr", k), ferrt - bf, 0);
      check($sformatf("tol%0d_data", k), bust.data, 8'h96);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

`default_nettype wire
